// File: rtl/project_arb_pkg.sv
// project_arb shared types and widths.
package project_arb_pkg;

  localparam int unsigned SYM_W = 4;
  localparam int unsigned RES_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RESP
  } arb_state_t;

endpackage

// File: rtl/project_arb_rr_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo NUM_REQ.
module rr_pick
  import project_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  // Modulo wrap keeps cand below NUM_REQ, so unused ids are never visited.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(last) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/project_arb.sv
// project_arb: round-robin sequencer sharing one project FSM among NUM_REQ requesters.
// Optional: PROJ_ARB_STATS_EN adds the saturating txn_cnt output.
module project_arb
  import project_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ  = 4,
  parameter int unsigned  HOLD_CYC = 3,
  localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0][SYM_W-1:0] sym,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [SYM_W-1:0]              fsm_in,
  input  logic [RES_W-1:0]              fsm_out,
  output logic                          rsp_vld,
  output logic [ID_W-1:0]               rsp_id,
  output logic [RES_W-1:0]              rsp_data,
  output logic                          busy
`ifdef PROJ_ARB_STATS_EN
  ,
  output logic [15:0]                   txn_cnt
`endif
);

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYC);
  localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST_RST  = ID_W'(NUM_REQ - 1);

  arb_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  id;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_vld;
  logic             hold_done;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req),
    .last  (last_grant),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign hold_done = (cnt == HOLD_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld)  state_nx = HOLD;
      HOLD:    if (hold_done) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // fsm_in is only written at a grant so the shared FSM never sees a spurious 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      fsm_in     <= '0;
      rsp_vld    <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      cnt        <= '0;
      id         <= '0;
      last_grant <= LAST_RST;
    end else begin
      gnt     <= '0;
      rsp_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt    <= GNT_ONE << pick_idx;
            fsm_in <= sym[pick_idx];
            id     <= pick_idx;
            cnt    <= CNT_W'(1);
          end
        end
        HOLD: begin
          if (hold_done) begin
            rsp_data <= fsm_out;
            rsp_id   <= id;
            rsp_vld  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP:    last_grant <= id;
        default: ;
      endcase
    end
  end

`ifdef PROJ_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       txn_cnt <= '0;
    else if (state == HOLD && hold_done && txn_cnt != '1) txn_cnt <= txn_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_project_arb.sv
// Self-checking bench for project_arb; honours PROJ_ARB_STATS_EN when defined.
module tb_project_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned HC = 3;
  localparam int unsigned IW = 2;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic [N-1:0]      req      = '0;
  logic [N-1:0][3:0] sym      = '0;
  logic [1:0]        fsm_out  = '0;
  logic [N-1:0]      gnt;
  logic [3:0]        fsm_in;
  logic              rsp_vld;
  logic [IW-1:0]     rsp_id;
  logic [1:0]        rsp_data;
  logic              busy;
`ifdef PROJ_ARB_STATS_EN
  logic [15:0]       txn_cnt;
`endif

  int total = 0;
  int bad   = 0;

  project_arb #(
    .NUM_REQ  (N),
    .HOLD_CYC (HC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .sym      (sym),
    .gnt      (gnt),
    .fsm_in   (fsm_in),
    .fsm_out  (fsm_out),
    .rsp_vld  (rsp_vld),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
`ifdef PROJ_ARB_STATS_EN
    ,
    .txn_cnt  (txn_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is described by its grant cycle and id;
  // every output follows from the cycle distance to that grant.
  int          cyc    = 0;
  bit          act    = 1'b0;
  int          g_cyc  = 0;
  int          g_id   = 0;
  int          m_last = N - 1;
  int          mc;
  bit          found;
  logic [3:0]  e_fsm_in = '0;
  logic [1:0]  e_data   = '0;
  logic [IW-1:0] e_id   = '0;
  logic [15:0] m_cnt    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act      = 1'b0;
      m_last   = N - 1;
      e_fsm_in = '0;
      e_data   = '0;
      e_id     = '0;
      m_cnt    = '0;
    end else begin
      cyc++;
      if (act) begin
        if (cyc - g_cyc == int'(HC)) begin
          e_data = fsm_out;
          e_id   = IW'(g_id);
          if (m_cnt != 16'hFFFF) m_cnt++;
        end else if (cyc - g_cyc == int'(HC) + 1) begin
          act    = 1'b0;
          m_last = g_id;
        end
      end else if (req != '0) begin
        found = 1'b0;
        for (int i = 1; i <= int'(N); i++) begin
          mc = (m_last + i) % int'(N);
          if (!found && req[mc]) begin
            found = 1'b1;
            g_id  = mc;
          end
        end
        act      = 1'b1;
        g_cyc    = cyc;
        e_fsm_in = sym[g_id];
      end
    end
  end

  int age;
  always @(negedge clk) begin
    age = cyc - g_cyc;
    chk("gnt",      32'(gnt),      (act && age == 0) ? (32'd1 << g_id) : 32'd0);
    chk("busy",     32'(busy),     32'(act));
    chk("rsp_vld",  32'(rsp_vld),  32'(act && age == int'(HC)));
    chk("fsm_in",   32'(fsm_in),   32'(e_fsm_in));
    chk("rsp_id",   32'(rsp_id),   32'(e_id));
    chk("rsp_data", 32'(rsp_data), 32'(e_data));
`ifdef PROJ_ARB_STATS_EN
    chk("txn_cnt",  32'(txn_cnt),  32'(m_cnt));
`endif
  end

  task automatic wait_gnt(input string name, input logic [N-1:0] exp, output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 20);
    at = cyc;
    chk(name, 32'(gnt), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int t_prev, t_now;

  initial begin
    // 1: reset with every request high
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    chk("t1_gnt",  32'(gnt), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_out",  32'({fsm_in, rsp_vld, rsp_id, rsp_data}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (6) @(negedge clk);

    // 2: single requester 2, late SYM change ignored
    req = 4'b0100; sym[2] = 4'b0101; fsm_out = 2'b01;
    @(negedge clk);
    chk("t2_gnt", 32'(gnt), 32'h4);
    chk("t2_in1", 32'(fsm_in), 32'h5);
    req = '0; sym[2] = 4'hF;
    @(negedge clk);
    chk("t2_in2", 32'(fsm_in), 32'h5);
    @(negedge clk);
    chk("t2_in3", 32'(fsm_in), 32'h5);
    fsm_out = 2'b10;
    @(negedge clk);
    chk("t2_vld",  32'(rsp_vld), 32'h1);
    chk("t2_id",   32'(rsp_id), 32'h2);
    chk("t2_data", 32'(rsp_data), 32'h2);
    chk("t2_in4",  32'(fsm_in), 32'h5);
    fsm_out = 2'b00;
    @(negedge clk);
    chk("t2_vld_off", 32'(rsp_vld), 32'h0);
    chk("t2_hold",    32'({rsp_id, rsp_data}), 32'({2'd2, 2'b10}));
    repeat (3) @(negedge clk);

    // 3: all requesting continuously
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("t3_order", 4'(1 << (k % 4)), t_now);
      if (k > 0) chk("t3_gap", 32'(t_now - t_prev), 32'd5);
      t_prev = t_now;
      repeat (HC) @(negedge clk);
      chk("t3_rsp_id", 32'({rsp_vld, rsp_id}), 32'({1'b1, 2'(k % 4)}));
    end
    req = '0;
    repeat (6) @(negedge clk);

    // 4: 1010 after a grant to 1
    do_reset();
    req = 4'b0010;
    wait_gnt("t4_g1", 4'b0010, t_now);
    req = 4'b1010;
    wait_gnt("t4_g3", 4'b1000, t_now);
    wait_gnt("t4_g1b", 4'b0010, t_now);
    req = '0;
    repeat (6) @(negedge clk);

    // 5: reset pulse in the second hold cycle aborts the transaction
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    chk("t5_gnt0", 32'(gnt), 32'h1);
    req = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_zero", 32'({gnt, fsm_in, rsp_vld, rsp_id, rsp_data, busy}), 32'h0);
    #1 rst_n = 1'b1;
    req = 4'b1001; sym[0] = 4'h3; sym[3] = 4'hC;
    @(negedge clk);
    chk("t5_regnt", 32'(gnt), 32'h1);
    req = 4'b1000;
    @(negedge clk);
    chk("t5_no_rsp", 32'(rsp_vld), 32'h0);
    req = '0;
    repeat (8) @(negedge clk);

`ifdef PROJ_ARB_STATS_EN
    // 6: transaction counter and saturation
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req = 4'b0001;
      wait_gnt("t6_gnt", 4'b0001, t_now);
      req = '0;
      repeat (4) @(negedge clk);
    end
    chk("t6_cnt3", 32'(txn_cnt), 32'd3);
    force dut.txn_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.txn_cnt;
    req = 4'b0001;
    wait_gnt("t6_gnt_sat", 4'b0001, t_now);
    req = '0;
    repeat (4) @(negedge clk);
    chk("t6_sat", 32'(txn_cnt), 32'hFFFF);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      fsm_out = 2'($urandom);
      for (int i = 0; i < int'(N); i++) begin
        sym[i] = 4'($urandom);
        if (gnt[i])       req[i] = ($urandom_range(0, 2) == 0);
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
      end
      if (c == 700) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    req = '0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
